vpath_load_arbiter: RTL and testbench
=====================================

VPATH_LOAD_ARBITER -- requirements
Module: vpath_load_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NREQ, 4, number of requesters (2..8).
- DW, 12, voltage code width.
- PIPE_LAT, 2, register stages between Dout and the load register input (1..7).
- CLAMP_LO, 0, lower code limit (used only with VPATH_CLAMP_EN).
- CLAMP_HI, 4095, upper code limit (used only with VPATH_CLAMP_EN).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- Clock, in, 1, single clock; all state on its rising edge.
- Reset_n, in, 1, asynchronous active-low reset.
- Req, in, NREQ, per-requester level request; held until Gnt.
- ReqData, in, NREQ*DW, requester i code at bits [i*DW +: DW].
- Gnt, out, NREQ, one-hot one-cycle pulse: request accepted.
- Done, out, NREQ, one-hot one-cycle pulse: code loaded into path register.
- Dout, out, DW, code driven into the voltage path Din.
- EN, out, 1, load enable to the path output register.
- Busy, out, 1, high while a transaction is in flight.
- ClampHit, out, 1, one-cycle pulse when the accepted code was clamped.

Function
REQ-003 The FSM SHALL have states IDLE, WAIT and LOAD; one transaction in flight at a time.
REQ-004 In IDLE with any Req bit high, the block SHALL register the winner's code into Dout, pulse Gnt[winner] and enter WAIT with a counter loaded with PIPE_LAT-1, all on the same edge.
REQ-005 Arbitration SHALL be round-robin: search starts at the index after the last granted, wrapping from NREQ-1 to 0.
REQ-006 WAIT SHALL decrement the counter each cycle and enter LOAD when it reaches 0.
REQ-007 LOAD SHALL last one cycle with EN=1 and Done[winner]=1, then return to IDLE.
REQ-008 EN SHALL be high exactly PIPE_LAT cycles after the cycle in which Dout first shows the new code.
REQ-009 Throughput SHALL be one load per PIPE_LAT+1 cycles under continuous requests.
REQ-010 Dout SHALL hold its value between grants; EN SHALL be 0 outside LOAD, so stale pipeline contents are never loaded.
REQ-011 Req bits seen while not in IDLE SHALL be ignored until IDLE; a Req dropped before grant SHALL receive no Gnt.
REQ-012 Busy SHALL be 1 in WAIT and LOAD and 0 in IDLE.
REQ-013 Gnt, Done, EN and ClampHit SHALL be registered outputs.

Reset
REQ-014 Reset_n low SHALL asynchronously force: IDLE state, Dout=0, EN=0, Gnt=0, Done=0, Busy=0, ClampHit=0, counter=0.
REQ-015 The round-robin pointer SHALL reset so that requester 0 has first priority.
REQ-016 Reset during WAIT or LOAD SHALL abort the transaction with no Done pulse; release resumes from IDLE.

Configuration
REQ-017 With VPATH_CLAMP_EN defined, an accepted code below CLAMP_LO or above CLAMP_HI SHALL be replaced by that limit before entering Dout, and ClampHit SHALL pulse with Gnt.
REQ-018 Without VPATH_CLAMP_EN, codes SHALL pass unchanged and ClampHit SHALL be tied to 0; the port list SHALL be identical in both builds.

Structure
REQ-019 Package vpath_ctrl_pkg SHALL hold the state enum, the default DW, and the counter-width constant.
REQ-020 Round-robin selection SHALL be a sub-module vpath_rr_arb (inputs Req and pointer; outputs one-hot grant and index).

Verification
REQ-021 Single request: Req=0001, ReqData[0]=0x5A3, PIPE_LAT=2, with Reset_n low then released.
- Gnt[0] pulses at cycle t and Dout=0x5A3 from t.
- EN and Done[0] pulse at t+2.
- Busy is high for t..t+2.
REQ-022 All four requesting continuously: grants occur in order 0,1,2,3,0 at 3-cycle spacing.
REQ-023 Req[2] drops while requester 1 is in WAIT: Req[2] receives no Gnt and the next grant goes to 3.
REQ-024 Reset_n pulled low in WAIT: EN, Done and Dout are 0 immediately and no Done follows release; the next request from requester 0 is granted first.
REQ-025 VPATH_CLAMP_EN defined with CLAMP_HI=3000 and ReqData=0xFFF: Dout=3000 (0xBB8) and ClampHit pulses with Gnt; without the macro, Dout=0xFFF and ClampHit stays 0.

Source files
------------

// File: rtl/vpath_ctrl_pkg.sv
// Shared definitions for the voltage-path load arbiter: controller state
// encoding, default code width and the width of the pipeline wait counter.
package vpath_ctrl_pkg;

    // Controller states: arbitrate, wait for the Dout pipeline, pulse the load.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LOAD = 2'd2
    } vpath_state_e;

    // Default width of a voltage code.
    localparam int DEFAULT_DW = 12;

    // Deepest supported Dout-to-load-register pipeline.
    localparam int MAX_PIPE_LAT = 7;

    // The wait counter holds PIPE_LAT-1 at most, so three bits cover 1..7.
    localparam int CNT_W = 3;

endpackage

// File: rtl/vpath_rr_arb.sv
// Round-robin selector. It searches from the requester after 'ptr' upward,
// wrapping at NREQ-1, and returns the first active request as a one-hot
// grant plus its index. The logic is purely combinational; the caller owns
// the pointer register and decides when a grant is actually taken.
module vpath_rr_arb
    import vpath_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx
);

    // One extra bit so ptr + offset cannot overflow before the wrap subtract.
    localparam int SUM_W = IDX_W + 1;

    logic             found;
    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] cand_idx;

    // Walk the NREQ candidates in priority order and keep the first hit.
    always_comb begin
        gnt      = '0;
        idx      = '0;
        found    = 1'b0;
        sum      = '0;
        cand_idx = '0;
        for (int off = 1; off <= NREQ; off++) begin
            sum = {1'b0, ptr} + SUM_W'(off);
            if (sum >= SUM_W'(NREQ)) begin
                sum = sum - SUM_W'(NREQ);
            end
            cand_idx = sum[IDX_W-1:0];
            if (!found && req[cand_idx]) begin
                found         = 1'b1;
                gnt[cand_idx] = 1'b1;
                idx           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/vpath_load_arbiter.sv
// Voltage-path load arbiter. Several requesters compete for one voltage path.
// The winner's code is registered onto Dout, and the path output register is
// enabled PIPE_LAT cycles later, once the code has crossed the PIPE_LAT
// register stages between Dout and that register. Only one transaction is in
// flight at a time.
//
// Build option: define VPATH_CLAMP_EN to limit accepted codes to
// [CLAMP_LO, CLAMP_HI] and report substitutions on ClampHit. Without the
// macro, codes pass unchanged and ClampHit is constant 0. The port list is
// the same in both builds.
module vpath_load_arbiter
    import vpath_ctrl_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DW       = DEFAULT_DW,
    parameter int PIPE_LAT = 2,
    parameter int CLAMP_LO = 0,
    parameter int CLAMP_HI = 4095
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic [NREQ-1:0]     Req,
    input  logic [NREQ*DW-1:0]  ReqData,
    output logic [NREQ-1:0]     Gnt,
    output logic [NREQ-1:0]     Done,
    output logic [DW-1:0]       Dout,
    output logic                EN,
    output logic                Busy,
    output logic                ClampHit
);

`ifdef VPATH_CLAMP_EN
    localparam bit CLAMP_ON = 1'b1;
`else
    localparam bit CLAMP_ON = 1'b0;
`endif

    localparam int               IDX_W     = $clog2(NREQ);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(PIPE_LAT - 1);
    localparam logic [DW-1:0]    LIMIT_LO  = DW'(CLAMP_LO);
    localparam logic [DW-1:0]    LIMIT_HI  = DW'(CLAMP_HI);
    // Pointer starts on the last requester so that requester 0 is searched first.
    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NREQ - 1);
    localparam logic [NREQ-1:0]  ONE_HOT0  = NREQ'(1);

    vpath_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic [DW-1:0]    dout_q, dout_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             en_q, en_d;
    logic             clamp_q, clamp_d;

    logic             any_req;
    logic             accept;
    logic [NREQ-1:0]  arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic [DW-1:0]    code_raw;
    logic [DW-1:0]    code_sel;
    logic             code_clamped;
    int               code_int;

    vpath_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arb (
        .req (Req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // A new transaction starts from IDLE, and also on the edge that closes
    // LOAD. The controller is back in IDLE on that edge, so back-to-back
    // requests are served every PIPE_LAT+1 cycles. Requests are not looked at
    // during WAIT.
    assign any_req = |Req;
    assign accept  = any_req && ((state_q == IDLE) || (state_q == LOAD));

    // Fetch the code of the requester the arbiter currently selects.
    always_comb begin
        code_raw = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                code_raw = ReqData[i*DW +: DW];
            end
        end
    end

    // Optionally force the code into the legal window and flag substitutions.
    always_comb begin
        code_sel     = code_raw;
        code_clamped = 1'b0;
        code_int     = int'(code_raw);
        if (CLAMP_ON) begin
            if (code_int < CLAMP_LO) begin
                code_sel     = LIMIT_LO;
                code_clamped = 1'b1;
            end else if (code_int > CLAMP_HI) begin
                code_sel     = LIMIT_HI;
                code_clamped = 1'b1;
            end
        end
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: grant, then wait out the pipeline, then load for one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = any_req ? WAIT : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs and datapath: capture the winner on accept, count down in
    // WAIT, and raise EN and Done for the cycle spent in LOAD.
    always_comb begin
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        dout_d  = dout_q;
        gnt_d   = '0;
        done_d  = '0;
        en_d    = 1'b0;
        clamp_d = 1'b0;

        if (accept) begin
            dout_d  = code_sel;
            gnt_d   = arb_gnt;
            clamp_d = code_clamped;
            cnt_d   = CNT_LOAD;
            ptr_d   = arb_idx;
            win_d   = arb_idx;
        end

        if (state_q == WAIT) begin
            if (cnt_q == '0) begin
                en_d   = 1'b1;
                done_d = ONE_HOT0 << win_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Registered outputs and transaction bookkeeping.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q   <= '0;
            ptr_q   <= PTR_RESET;
            win_q   <= '0;
            dout_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            en_q    <= 1'b0;
            clamp_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            dout_q  <= dout_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            en_q    <= en_d;
            clamp_q <= clamp_d;
        end
    end

    assign Gnt      = gnt_q;
    assign Done     = done_q;
    assign Dout     = dout_q;
    assign EN       = en_q;
    assign ClampHit = clamp_q;
    assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_vpath_load_arbiter.sv
// Directed bench for vpath_load_arbiter (NREQ=4, DW=12, PIPE_LAT=2,
// CLAMP_HI=3000). Expected grants and loads are queued when requests are
// driven. A negedge monitor pops and checks each queued entry when the DUT
// pulses Gnt or Done. Define VPATH_CLAMP_EN to select the clamped build.
module tb_vpath_load_arbiter;

    localparam int NREQ        = 4;
    localparam int DW          = 12;
    localparam int PIPE_LAT    = 2;
    localparam int CLAMP_HI_TB = 3000;

`ifdef VPATH_CLAMP_EN
    localparam bit CLAMP_ON = 1'b1;
`else
    localparam bit CLAMP_ON = 1'b0;
`endif

    typedef struct {
        int            idx;
        logic [DW-1:0] code;
        logic          clamp;
    } exp_t;

    logic               Clock = 1'b0;
    logic               Reset_n;
    logic [NREQ-1:0]    Req;
    logic [NREQ*DW-1:0] ReqData;
    logic [NREQ-1:0]    Gnt;
    logic [NREQ-1:0]    Done;
    logic [DW-1:0]      Dout;
    logic               EN;
    logic               Busy;
    logic               ClampHit;

    exp_t gntQ[$];
    exp_t doneQ[$];
    exp_t monGnt;
    exp_t monDone;

    int checkCount = 0;
    int errCount   = 0;
    int cycleCount = 0;

    vpath_load_arbiter #(
        .NREQ     (NREQ),
        .DW       (DW),
        .PIPE_LAT (PIPE_LAT),
        .CLAMP_LO (0),
        .CLAMP_HI (CLAMP_HI_TB)
    ) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .Req      (Req),
        .ReqData  (ReqData),
        .Gnt      (Gnt),
        .Done     (Done),
        .Dout     (Dout),
        .EN       (EN),
        .Busy     (Busy),
        .ClampHit (ClampHit)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cycleCount++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Change the request vector just after a rising edge.
    task automatic applyStimulus(input logic [NREQ-1:0] reqVec);
        @(posedge Clock);
        #1;
        Req = reqVec;
    endtask

    task automatic applyReset();
        @(posedge Clock);
        #1;
        Reset_n = 1'b0;
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic setCode(input int i, input logic [DW-1:0] code);
        ReqData[i*DW +: DW] = code;
    endtask

    function automatic exp_t makeExp(input int idx, input logic [DW-1:0] code);
        exp_t e;
        e.idx   = idx;
        e.clamp = CLAMP_ON && (int'(code) > CLAMP_HI_TB);
        e.code  = e.clamp ? DW'(CLAMP_HI_TB) : code;
        return e;
    endfunction

    task automatic pushExp(input int idx, input logic [DW-1:0] code);
        gntQ.push_back(makeExp(idx, code));
        doneQ.push_back(makeExp(idx, code));
    endtask

    task automatic waitGrant(input string tag, output int atCycle);
        int n = 0;
        @(negedge Clock);
        while (Gnt === '0 && n < 20) begin
            @(negedge Clock);
            n++;
        end
        checkOutput({tag, "_gnt_seen"}, 32'(Gnt !== '0), 32'd1);
        atCycle = cycleCount;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        @(negedge Clock);
        while (Busy !== 1'b0 && n < 20) begin
            @(negedge Clock);
            n++;
        end
        checkOutput({tag, "_idle"}, 32'(Busy), 32'd0);
    endtask

    // Scoreboard monitor: every Gnt and Done pulse must match the queue head.
    always @(negedge Clock) begin
        if (Reset_n === 1'b1 && Gnt !== '0) begin
            if (gntQ.size() == 0) begin
                checkOutput("unexpected_gnt", 32'(Gnt), 32'd0);
            end else begin
                monGnt = gntQ.pop_front();
                checkOutput("gnt_onehot", 32'(Gnt), 32'd1 << monGnt.idx);
                checkOutput("gnt_dout", 32'(Dout), 32'(monGnt.code));
                checkOutput("gnt_clamphit", 32'(ClampHit), 32'(monGnt.clamp));
            end
        end
        if (Reset_n === 1'b1 && Done !== '0) begin
            if (doneQ.size() == 0) begin
                checkOutput("unexpected_done", 32'(Done), 32'd0);
            end else begin
                monDone = doneQ.pop_front();
                checkOutput("done_onehot", 32'(Done), 32'd1 << monDone.idx);
                checkOutput("done_en", 32'(EN), 32'd1);
                checkOutput("done_dout", 32'(Dout), 32'(monDone.code));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] simulation did not finish in time");
    end

    initial begin
        int tGnt;
        int tPrev;
        tGnt    = 0;
        tPrev   = 0;
        Reset_n = 1'b0;
        Req     = '0;
        ReqData = '0;

        // Reset state.
        repeat (3) @(negedge Clock);
        checkOutput("rst_dout", 32'(Dout), 32'd0);
        checkOutput("rst_en", 32'(EN), 32'd0);
        checkOutput("rst_gnt", 32'(Gnt), 32'd0);
        checkOutput("rst_done", 32'(Done), 32'd0);
        checkOutput("rst_busy", 32'(Busy), 32'd0);
        checkOutput("rst_clamphit", 32'(ClampHit), 32'd0);
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;

        // Single request: grant at t, load at t+2, busy t..t+2.
        $display("[TB] single request");
        setCode(0, 12'h5A3);
        pushExp(0, 12'h5A3);
        applyStimulus(4'b0001);
        waitGrant("single", tGnt);
        checkOutput("single_busy_t0", 32'(Busy), 32'd1);
        checkOutput("single_en_t0", 32'(EN), 32'd0);
        applyStimulus(4'b0000);
        @(negedge Clock);
        checkOutput("single_busy_t1", 32'(Busy), 32'd1);
        checkOutput("single_en_t1", 32'(EN), 32'd0);
        checkOutput("single_done_t1", 32'(Done), 32'd0);
        @(negedge Clock);
        checkOutput("single_en_t2", 32'(EN), 32'd1);
        checkOutput("single_busy_t2", 32'(Busy), 32'd1);
        @(negedge Clock);
        checkOutput("single_busy_t3", 32'(Busy), 32'd0);
        checkOutput("single_en_t3", 32'(EN), 32'd0);
        checkOutput("single_dout_hold", 32'(Dout), 32'h5A3);

        // Continuous requests from all four: order 0,1,2,3,0 every 3 cycles.
        $display("[TB] round robin");
        applyReset();
        setCode(0, 12'h1A0);
        setCode(1, 12'h2B1);
        setCode(2, 12'h3C2);
        setCode(3, 12'h4D3);
        pushExp(0, 12'h1A0);
        pushExp(1, 12'h2B1);
        pushExp(2, 12'h3C2);
        pushExp(3, 12'h4D3);
        pushExp(0, 12'h1A0);
        applyStimulus(4'b1111);
        for (int k = 0; k < 5; k++) begin
            waitGrant("rr", tGnt);
            if (k > 0) begin
                checkOutput("rr_spacing", 32'(tGnt - tPrev), 32'(PIPE_LAT + 1));
            end
            tPrev = tGnt;
        end
        applyStimulus(4'b0000);
        waitIdle("rr");

        // Requester 2 withdraws while 1 is waiting; 3 must be next.
        $display("[TB] dropped request");
        pushExp(1, 12'h2B1);
        pushExp(3, 12'h4D3);
        applyStimulus(4'b1110);
        waitGrant("drop_first", tPrev);
        applyStimulus(4'b1000);
        waitGrant("drop_second", tGnt);
        checkOutput("drop_spacing", 32'(tGnt - tPrev), 32'(PIPE_LAT + 1));
        applyStimulus(4'b0000);
        waitIdle("drop");

        // Reset while waiting: abort without Done, priority back to 0.
        $display("[TB] reset abort");
        setCode(0, 12'h321);
        gntQ.push_back(makeExp(0, 12'h321));
        applyStimulus(4'b0001);
        waitGrant("abort", tGnt);
        applyStimulus(4'b0000);
        #1;
        Reset_n = 1'b0;
        #1;
        checkOutput("abort_en", 32'(EN), 32'd0);
        checkOutput("abort_done", 32'(Done), 32'd0);
        checkOutput("abort_dout", 32'(Dout), 32'd0);
        checkOutput("abort_busy", 32'(Busy), 32'd0);
        repeat (2) @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        repeat (4) @(negedge Clock);
        checkOutput("abort_busy_after", 32'(Busy), 32'd0);
        setCode(0, 12'h0AB);
        setCode(1, 12'h0CD);
        pushExp(0, 12'h0AB);
        pushExp(1, 12'h0CD);
        applyStimulus(4'b0011);
        waitGrant("abort_next0", tGnt);
        applyStimulus(4'b0010);
        waitGrant("abort_next1", tGnt);
        applyStimulus(4'b0000);
        waitIdle("abort");

        // Full-scale code: clamped to 3000 only in the clamp build.
        $display("[TB] clamp");
        setCode(2, 12'hFFF);
        pushExp(2, 12'hFFF);
        applyStimulus(4'b0100);
        waitGrant("clamp", tGnt);
        checkOutput("clamp_dout", 32'(Dout), CLAMP_ON ? 32'hBB8 : 32'hFFF);
        checkOutput("clamp_hit", 32'(ClampHit), 32'(CLAMP_ON));
        applyStimulus(4'b0000);
        @(negedge Clock);
        checkOutput("clamp_hit_end", 32'(ClampHit), 32'd0);
        waitIdle("clamp");

        checkOutput("gnt_queue_empty", 32'(gntQ.size()), 32'd0);
        checkOutput("done_queue_empty", 32'(doneQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
        $finish;
    end

endmodule
